// File: rtl/ysyx_24080006_pkg.sv
// Shared AXI4-Lite widths, arbiter state encoding and grant helper.
// Kept separate so the planned crossbar can reuse the same state type.
package ysyx_24080006_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;
    localparam int AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_e;

    // A write only wins when AW and W arrive together; the slave takes them as a pair.
    function automatic arb_state_e nextGrant(
        input logic lsuAwvalid,
        input logic lsuWvalid,
        input logic lsuArvalid,
        input logic ifuArvalid
    );
        if (lsuAwvalid && lsuWvalid) begin
            return LSU_WR;
        end else if (lsuArvalid) begin
            return LSU_RD;
        end else if (ifuArvalid) begin
            return IFU_RD;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/ysyx_24080006_axi.sv
// AXI4-Lite bundle; master drives requests, slave drives ready/response.
interface ysyx_24080006_axi;
    import ysyx_24080006_pkg::*;

    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [AXI_RESP_W-1:0] rresp;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_RESP_W-1:0] bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One outstanding transaction, LSU has fixed priority, routing is combinational.
module axi_arbiter
    import ysyx_24080006_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    ysyx_24080006_axi.slave       ifu,
    ysyx_24080006_axi.slave       lsu,
    ysyx_24080006_axi.master      mem
);

    arb_state_e r_state;
    logic       w_unusedIfuWrite;

    // The fetch port never writes, so its write-request lines are ignored.
    assign w_unusedIfuWrite = ^{ifu.awaddr, ifu.awvalid, ifu.wdata,
                                ifu.wstrb, ifu.wvalid, ifu.bready};

    // A grant is held until its response handshake completes; nothing preempts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= nextGrant(lsu.awvalid, lsu.wvalid,
                                         lsu.arvalid, ifu.arvalid);
                end
                IFU_RD: begin
                    if (mem.rvalid && ifu.rready) r_state <= IDLE;
                end
                LSU_RD: begin
                    if (mem.rvalid && lsu.rready) r_state <= IDLE;
                end
                LSU_WR: begin
                    if (mem.bvalid && lsu.bready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem.araddr  = '0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awaddr  = '0;
        mem.awvalid = 1'b0;
        mem.wdata   = '0;
        mem.wstrb   = '0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;

        ifu.arready = 1'b0;
        ifu.rdata   = '0;
        ifu.rresp   = '0;
        ifu.rvalid  = 1'b0;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bresp   = '0;
        ifu.bvalid  = 1'b0;

        lsu.arready = 1'b0;
        lsu.rdata   = '0;
        lsu.rresp   = '0;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = '0;
        lsu.bvalid  = 1'b0;

        case (r_state)
            IFU_RD: begin
                mem.araddr  = ifu.araddr;
                mem.arvalid = ifu.arvalid;
                mem.rready  = ifu.rready;
                ifu.arready = mem.arready;
                ifu.rdata   = mem.rdata;
                ifu.rresp   = mem.rresp;
                ifu.rvalid  = mem.rvalid;
            end
            LSU_RD: begin
                mem.araddr  = lsu.araddr;
                mem.arvalid = lsu.arvalid;
                mem.rready  = lsu.rready;
                lsu.arready = mem.arready;
                lsu.rdata   = mem.rdata;
                lsu.rresp   = mem.rresp;
                lsu.rvalid  = mem.rvalid;
            end
            LSU_WR: begin
                mem.awaddr  = lsu.awaddr;
                mem.awvalid = lsu.awvalid;
                mem.wdata   = lsu.wdata;
                mem.wstrb   = lsu.wstrb;
                mem.wvalid  = lsu.wvalid;
                mem.bready  = lsu.bready;
                lsu.awready = mem.awready;
                lsu.wready  = mem.wready;
                lsu.bresp   = mem.bresp;
                lsu.bvalid  = mem.bvalid;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter with a small one-cycle-latency memory slave.
module tb_axi_arbiter;
    import ysyx_24080006_pkg::*;

    logic clock;
    logic reset;

    ysyx_24080006_axi ifuBus ();
    ysyx_24080006_axi lsuBus ();
    ysyx_24080006_axi memBus ();

    axi_arbiter dut (
        .clock (clock),
        .reset (reset),
        .ifu   (ifuBus.slave),
        .lsu   (lsuBus.slave),
        .mem   (memBus.master)
    );

    int checkCount = 0;
    int failCount  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory slave: arready idles high, response one cycle after the handshake.
    logic        slaveRdPend;
    logic        slaveWrPend;
    logic [31:0] slaveRdData;
    logic [31:0] slaveMem [0:3];
    logic [31:0] slaveWrCount;
    logic [3:0]  slaveLastStrb;

    function automatic logic [31:0] mergeStrb(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  strb);
        logic [31:0] result;
        result = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[b*8 +: 8] = newWord[b*8 +: 8];
        end
        return result;
    endfunction

    assign memBus.arready = !slaveRdPend;
    assign memBus.rvalid  = slaveRdPend;
    assign memBus.rdata   = slaveRdData;
    assign memBus.rresp   = AXI_RESP_OKAY;
    assign memBus.awready = !slaveWrPend;
    assign memBus.wready  = !slaveWrPend;
    assign memBus.bvalid  = slaveWrPend;
    assign memBus.bresp   = AXI_RESP_OKAY;

    always_ff @(posedge clock) begin
        if (reset) begin
            slaveRdPend   <= 1'b0;
            slaveWrPend   <= 1'b0;
            slaveRdData   <= 32'h0;
            slaveWrCount  <= 32'h0;
            slaveLastStrb <= 4'h0;
            slaveMem[0]   <= 32'h0000_0413;
            slaveMem[1]   <= 32'h1234_5678;
            slaveMem[2]   <= 32'hCAFE_0000;
            slaveMem[3]   <= 32'h0000_0000;
        end else begin
            if (memBus.arvalid && memBus.arready) begin
                slaveRdPend <= 1'b1;
                slaveRdData <= slaveMem[memBus.araddr[13:12]];
            end else if (slaveRdPend && memBus.rready) begin
                slaveRdPend <= 1'b0;
            end
            if (memBus.awvalid && memBus.awready && memBus.wvalid && memBus.wready) begin
                slaveWrPend   <= 1'b1;
                slaveWrCount  <= slaveWrCount + 32'd1;
                slaveLastStrb <= memBus.wstrb;
                slaveMem[memBus.awaddr[13:12]] <= mergeStrb(slaveMem[memBus.awaddr[13:12]],
                                                            memBus.wdata, memBus.wstrb);
            end else if (slaveWrPend && memBus.bready) begin
                slaveWrPend <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifuAr, input logic lsuAr,
                                 input logic lsuAw, input logic lsuW);
        ifuBus.arvalid = ifuAr;
        lsuBus.arvalid = lsuAr;
        lsuBus.awvalid = lsuAw;
        lsuBus.wvalid  = lsuW;
    endtask

    // Drive point sits 1 time unit after the rising edge; sampling happens 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] stateVal();
        return 32'(dut.r_state);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ifuBus.araddr = 32'h0; ifuBus.rready = 1'b1;
        ifuBus.awaddr = 32'h0; ifuBus.awvalid = 1'b0;
        ifuBus.wdata  = 32'h0; ifuBus.wstrb = 4'h0; ifuBus.wvalid = 1'b0;
        ifuBus.bready = 1'b0;
        lsuBus.araddr = 32'h0; lsuBus.rready = 1'b1;
        lsuBus.awaddr = 32'h0; lsuBus.wdata = 32'h0; lsuBus.wstrb = 4'h0;
        lsuBus.bready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        settle();
        checkOutput("reset_state", stateVal(), 32'(IDLE));
        checkOutput("reset_mem_arvalid", 32'(memBus.arvalid), 32'd0);
        checkOutput("reset_ifu_arready", 32'(ifuBus.arready), 32'd0);
        checkOutput("reset_lsu_bvalid", 32'(lsuBus.bvalid), 32'd0);
        checkOutput("ifu_tie_awready", 32'(ifuBus.awready), 32'd0);

        // IFU read alone
        $display("[TB] IFU read alone");
        tick();
        ifuBus.araddr = 32'h8000_0000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("ifu_rd_n_state", stateVal(), 32'(IDLE));
        checkOutput("ifu_rd_n_memar", 32'(memBus.arvalid), 32'd0);
        tick(); settle();
        checkOutput("ifu_rd_n1_state", stateVal(), 32'(IFU_RD));
        checkOutput("ifu_rd_n1_araddr", memBus.araddr, 32'h8000_0000);
        checkOutput("ifu_rd_n1_arready", 32'(ifuBus.arready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("ifu_rd_n2_rvalid", 32'(ifuBus.rvalid), 32'd1);
        checkOutput("ifu_rd_n2_rdata", ifuBus.rdata, 32'h0000_0413);
        checkOutput("ifu_rd_n2_lsu_rvalid", 32'(lsuBus.rvalid), 32'd0);
        tick(); settle();
        checkOutput("ifu_rd_n3_state", stateVal(), 32'(IDLE));
        checkOutput("ifu_rd_n3_rvalid", 32'(ifuBus.rvalid), 32'd0);
        checkOutput("ifu_rd_n3_rdata", ifuBus.rdata, 32'h0);

        // Simultaneous IFU and LSU reads: LSU first
        $display("[TB] Simultaneous reads");
        tick();
        ifuBus.araddr = 32'h8000_0000;
        lsuBus.araddr = 32'h8000_1000;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("sim_n_ifu_arready", 32'(ifuBus.arready), 32'd0);
        tick(); settle();
        checkOutput("sim_n1_state", stateVal(), 32'(LSU_RD));
        checkOutput("sim_n1_araddr", memBus.araddr, 32'h8000_1000);
        checkOutput("sim_n1_lsu_arready", 32'(lsuBus.arready), 32'd1);
        checkOutput("sim_n1_ifu_arready", 32'(ifuBus.arready), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("sim_n2_lsu_rdata", lsuBus.rdata, 32'h1234_5678);
        checkOutput("sim_n2_ifu_arready", 32'(ifuBus.arready), 32'd0);
        checkOutput("sim_n2_ifu_rdata", ifuBus.rdata, 32'h0);
        tick(); settle();
        checkOutput("sim_n3_state", stateVal(), 32'(IDLE));
        tick(); settle();
        checkOutput("sim_n4_state", stateVal(), 32'(IFU_RD));
        checkOutput("sim_n4_araddr", memBus.araddr, 32'h8000_0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("sim_n5_ifu_rdata", ifuBus.rdata, 32'h0000_0413);
        tick(); settle();
        checkOutput("sim_n6_state", stateVal(), 32'(IDLE));

        // LSU partial-strobe write then read-back
        $display("[TB] LSU write");
        tick();
        lsuBus.awaddr = 32'h8000_2000;
        lsuBus.wdata  = 32'hDEAD_BEEF;
        lsuBus.wstrb  = 4'b0011;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        checkOutput("wr_n_state", stateVal(), 32'(IDLE));
        checkOutput("wr_n_mem_awvalid", 32'(memBus.awvalid), 32'd0);
        tick(); settle();
        checkOutput("wr_n1_state", stateVal(), 32'(LSU_WR));
        checkOutput("wr_n1_awaddr", memBus.awaddr, 32'h8000_2000);
        checkOutput("wr_n1_wdata", memBus.wdata, 32'hDEAD_BEEF);
        checkOutput("wr_n1_wstrb", 32'(memBus.wstrb), 32'h3);
        checkOutput("wr_n1_awready", 32'(lsuBus.awready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("wr_n2_bvalid", 32'(lsuBus.bvalid), 32'd1);
        checkOutput("wr_n2_bresp", 32'(lsuBus.bresp), 32'd0);
        checkOutput("wr_n2_count", slaveWrCount, 32'd1);
        checkOutput("wr_n2_strb", 32'(slaveLastStrb), 32'h3);
        tick(); settle();
        checkOutput("wr_n3_bvalid", 32'(lsuBus.bvalid), 32'd0);
        checkOutput("wr_n3_state", stateVal(), 32'(IDLE));
        tick();
        lsuBus.araddr = 32'h8000_2000;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("wr_readback", lsuBus.rdata, 32'hCAFE_BEEF);
        tick(); settle();
        checkOutput("wr_readback_idle", stateVal(), 32'(IDLE));

        // AW without W must not win; IFU gets through meanwhile
        $display("[TB] Partial write request");
        tick();
        lsuBus.awaddr = 32'h8000_3000;
        lsuBus.wdata  = 32'h0000_00AA;
        lsuBus.wstrb  = 4'b1111;
        ifuBus.araddr = 32'h8000_0000;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(); settle();
        checkOutput("pw_n1_state", stateVal(), 32'(IFU_RD));
        checkOutput("pw_n1_lsu_awready", 32'(lsuBus.awready), 32'd0);
        checkOutput("pw_n1_mem_awvalid", 32'(memBus.awvalid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        checkOutput("pw_n2_ifu_rvalid", 32'(ifuBus.rvalid), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        checkOutput("pw_n3_state", stateVal(), 32'(IDLE));
        tick(); settle();
        checkOutput("pw_n4_state", stateVal(), 32'(LSU_WR));
        checkOutput("pw_n4_awaddr", memBus.awaddr, 32'h8000_3000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("pw_n5_bvalid", 32'(lsuBus.bvalid), 32'd1);
        checkOutput("pw_n5_count", slaveWrCount, 32'd2);
        tick(); settle();
        checkOutput("pw_n6_state", stateVal(), 32'(IDLE));

        // IFU rready backpressure with an LSU read waiting
        $display("[TB] Backpressure");
        tick();
        ifuBus.araddr = 32'h8000_0000;
        ifuBus.rready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(); settle();
        checkOutput("bp_n1_state", stateVal(), 32'(IFU_RD));
        tick();
        lsuBus.araddr = 32'h8000_1000;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("bp_hold%0d_state", c), stateVal(), 32'(IFU_RD));
            checkOutput($sformatf("bp_hold%0d_rvalid", c), 32'(memBus.rvalid), 32'd1);
            checkOutput($sformatf("bp_hold%0d_lsu_arready", c), 32'(lsuBus.arready), 32'd0);
            tick();
        end
        ifuBus.rready = 1'b1;
        settle();
        checkOutput("bp_release_state", stateVal(), 32'(IFU_RD));
        tick(); settle();
        checkOutput("bp_idle_state", stateVal(), 32'(IDLE));
        tick(); settle();
        checkOutput("bp_lsu_grant", stateVal(), 32'(LSU_RD));
        checkOutput("bp_lsu_araddr", memBus.araddr, 32'h8000_1000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("bp_lsu_rdata", lsuBus.rdata, 32'h1234_5678);
        tick(); settle();
        checkOutput("bp_end_state", stateVal(), 32'(IDLE));

        // Reset pulse while a write response is pending
        $display("[TB] Reset during LSU_WR");
        tick();
        lsuBus.awaddr = 32'h8000_3000;
        lsuBus.wdata  = 32'h5555_5555;
        lsuBus.wstrb  = 4'b1111;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        lsuBus.bready = 1'b0;
        settle();
        checkOutput("rst_pre_bvalid", 32'(lsuBus.bvalid), 32'd1);
        checkOutput("rst_pre_state", stateVal(), 32'(LSU_WR));
        tick();
        reset = 1'b1;
        settle();
        checkOutput("rst_hold_mem_bvalid", 32'(memBus.bvalid), 32'd1);
        tick();
        reset = 1'b0;
        lsuBus.bready = 1'b1;
        settle();
        checkOutput("rst_post_state", stateVal(), 32'(IDLE));
        checkOutput("rst_post_lsu_bvalid", 32'(lsuBus.bvalid), 32'd0);
        checkOutput("rst_post_mem_valids",
                    32'({memBus.arvalid, memBus.awvalid, memBus.wvalid, memBus.rvalid, memBus.bvalid}),
                    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
